// File: rtl/cond_logic.sv
// cond_logic: conditional-execution and flag-holding stage behind the ALU.
// Stores {N,Z,C,V} under the decoder's flag-write enables, checks each
// instruction's condition field against the stored flags, and gates the
// PC / register / memory write strobes with the result.
//
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   Cond[3:0]       instruction condition field
//   ALUFlags[3:0]   {N,Z,C,V} produced by the ALU for this instruction
//   FlagW[1:0]      [1] writes N,Z; [0] writes C,V
//   PCS/RegW/MemW   ungated decoder write strobes
//   NoWrite         compare-type op, suppresses RegWrite only
//   Stall           pipeline hold: freezes flags, suppresses all strobes
//   PCSrc/RegWrite/MemWrite  gated strobes (combinational)
//   CondEx          condition passed (combinational)
//   Flags[3:0]      stored {N,Z,C,V}
module cond_logic (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    input  logic       Stall,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    localparam int unsigned FLAG_W = 4;

    logic [FLAG_W-1:0] flags_q;
    logic [FLAG_W-1:0] flags_d;
    logic              n_flag;
    logic              z_flag;
    logic              c_flag;
    logic              v_flag;
    logic              cond_ex;
    logic              write_ok;

    assign {n_flag, z_flag, c_flag, v_flag} = flags_q;

    // Condition evaluation against the stored flags only.
    always_comb begin
        cond_ex = 1'b0;
        case (Cond)
            4'b0000: cond_ex = z_flag;
            4'b0001: cond_ex = ~z_flag;
            4'b0010: cond_ex = c_flag;
            4'b0011: cond_ex = ~c_flag;
            4'b0100: cond_ex = n_flag;
            4'b0101: cond_ex = ~n_flag;
            4'b0110: cond_ex = v_flag;
            4'b0111: cond_ex = ~v_flag;
            4'b1000: cond_ex = c_flag & ~z_flag;
            4'b1001: cond_ex = ~c_flag | z_flag;
            4'b1010: cond_ex = (n_flag == v_flag);
            4'b1011: cond_ex = (n_flag != v_flag);
            4'b1100: cond_ex = ~z_flag & (n_flag == v_flag);
            4'b1101: cond_ex = z_flag | (n_flag != v_flag);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // An instruction may commit only if its condition passed and it is not held.
    assign write_ok = cond_ex & ~Stall;

    // NZ and CV fields update independently; each holds unless its enable fires.
    always_comb begin
        flags_d = flags_q;
        if (FlagW[1] && write_ok) begin
            flags_d[3:2] = ALUFlags[3:2];
        end
        if (FlagW[0] && write_ok) begin
            flags_d[1:0] = ALUFlags[1:0];
        end
    end

    // Flag register; reset overrides any pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags_q <= FLAG_W'(0);
        end else begin
            flags_q <= flags_d;
        end
    end

    assign CondEx   = cond_ex;
    assign PCSrc    = PCS & write_ok;
    assign RegWrite = RegW & write_ok & ~NoWrite;
    assign MemWrite = MemW & write_ok;
    assign Flags    = flags_q;

endmodule
